// File: rtl/mips_ctrl_pkg.sv
// mips_ctrl_pkg: shared definitions for the multicycle MIPS control path.
//   state_t          - main control FSM state encoding (4 bits, exported on state_out)
//   OP_*             - primary opcode values (IR[31:26])
//   ULA_*            - ALU operation class handed to the ALU control decoder
//   SRCB_* / PCSRC_* - datapath mux select encodings
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    S_RESET     = 4'd0,
    S_FETCH     = 4'd1,
    S_DECODE    = 4'd2,
    S_MEM_ADDR  = 4'd3,
    S_MEM_READ  = 4'd4,
    S_LOAD_WB   = 4'd5,
    S_MEM_WRITE = 4'd6,
    S_R_EXEC    = 4'd7,
    S_R_WB      = 4'd8,
    S_BRANCH    = 4'd9,
    S_JUMP      = 4'd10,
    S_ADDI_EXEC = 4'd11,
    S_ADDI_WB   = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_ADDI  = 6'h08;

  localparam logic [1:0] ULA_ADD   = 2'b00;
  localparam logic [1:0] ULA_SUB   = 2'b01;
  localparam logic [1:0] ULA_RTYPE = 2'b10;

  localparam logic [1:0] SRCB_B       = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // States that touch memory and are therefore stretched by the wait counter.
  function automatic logic is_wait_state(input state_t s);
    return (s == S_FETCH) || (s == S_MEM_READ) || (s == S_MEM_WRITE);
  endfunction

endpackage

// File: rtl/mem_wait_counter.sv
// mem_wait_counter: 4-bit cycle counter that stretches memory accesses.
//   clk     - system clock
//   rst     - asynchronous active-high reset
//   clr_i   - clear count to 0 (wins over inc_i)
//   inc_i   - increment count
//   done_o  - count has reached MEM_WAIT (final cycle of the access)
module mem_wait_counter #(
  parameter int unsigned MEM_WAIT = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic inc_i,
  output logic done_o
);

  localparam logic [3:0] WAIT_LIMIT = 4'(MEM_WAIT);

  logic [3:0] count_q;
  logic [3:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = 4'd0;
    end else if (inc_i) begin
      count_d = count_q + 4'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= 4'd0;
    end else begin
      count_q <= count_d;
    end
  end

  assign done_o = (count_q == WAIT_LIMIT);

endmodule

// File: rtl/main_control_fsm.sv
// main_control_fsm: Moore main control unit of a multicycle MIPS datapath.
// Sequences fetch/decode/execute/memory/write-back and drives every datapath
// enable and mux select. Outputs depend only on the state register and the
// memory wait counter, never directly on opcode.
//   clk, reset         - clock, asynchronous active-high reset
//   opcode             - IR[31:26], sampled only in DECODE
//   PCWrite/PCWriteCond, IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
//   ALUSrcA, ALUSrcB, ULAOp, PCSource - datapath controls
//   state_out          - current state encoding for debug
module main_control_fsm
  import mips_ctrl_pkg::*;
#(
  parameter int unsigned MEM_WAIT = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ULAOp,
  output logic [1:0] PCSource,
  output logic [3:0] state_out
);

  state_t     state_q;
  state_t     state_d;
  logic [5:0] opcode_q;
  logic       wait_done;
  logic       in_wait;

  // The counter is held at zero outside memory states and cleared as a memory
  // state exits, so it always starts from zero on entry.
  assign in_wait = is_wait_state(state_q);

  mem_wait_counter #(.MEM_WAIT(MEM_WAIT)) u_wait (
    .clk   (clk),
    .rst   (reset),
    .clr_i (!in_wait || wait_done),
    .inc_i (in_wait && !wait_done),
    .done_o(wait_done)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_RESET;
      opcode_q <= 6'd0;
    end else begin
      state_q <= state_d;
      // Latched so MEM_ADDR can pick lw/sw without relying on live IR.
      if (state_q == S_DECODE) begin
        opcode_q <= opcode;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_RESET:     state_d = S_FETCH;
      S_FETCH:     if (wait_done) state_d = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: state_d = S_MEM_ADDR;
          OP_RTYPE:     state_d = S_R_EXEC;
          OP_BEQ:       state_d = S_BRANCH;
          OP_J:         state_d = S_JUMP;
          OP_ADDI:      state_d = S_ADDI_EXEC;
          default:      state_d = S_FETCH;  // unknown opcode retires as a NOP
        endcase
      end
      S_MEM_ADDR:  state_d = (opcode_q == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
      S_MEM_READ:  if (wait_done) state_d = S_LOAD_WB;
      S_LOAD_WB:   state_d = S_FETCH;
      S_MEM_WRITE: if (wait_done) state_d = S_FETCH;
      S_R_EXEC:    state_d = S_R_WB;
      S_R_WB:      state_d = S_FETCH;
      S_BRANCH:    state_d = S_FETCH;
      S_JUMP:      state_d = S_FETCH;
      S_ADDI_EXEC: state_d = S_ADDI_WB;
      S_ADDI_WB:   state_d = S_FETCH;
      default:     state_d = S_RESET;
    endcase
  end

  always_comb begin
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    RegDst      = 1'b0;
    MemtoReg    = 1'b0;
    RegWrite    = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = SRCB_B;
    ULAOp       = ULA_ADD;
    PCSource    = PCSRC_ALU;
    unique case (state_q)
      S_FETCH: begin
        ALUSrcB = SRCB_FOUR;
        // Load IR and PC+4 only once the memory data is ready.
        IRWrite = wait_done;
        PCWrite = wait_done;
      end
      S_DECODE: begin
        ALUSrcB = SRCB_IMM_SH2;  // precompute branch target
      end
      S_MEM_ADDR, S_ADDI_EXEC: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
      end
      S_MEM_READ: begin
        IorD = 1'b1;
      end
      S_LOAD_WB: begin
        MemtoReg = 1'b1;
        RegWrite = 1'b1;
      end
      S_MEM_WRITE: begin
        IorD     = 1'b1;
        MemWrite = wait_done;
      end
      S_R_EXEC: begin
        ALUSrcA = 1'b1;
        ULAOp   = ULA_RTYPE;
      end
      S_R_WB: begin
        RegDst   = 1'b1;
        RegWrite = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA     = 1'b1;
        ULAOp       = ULA_SUB;
        PCWriteCond = 1'b1;
        PCSource    = PCSRC_ALUOUT;
      end
      S_JUMP: begin
        PCWrite  = 1'b1;
        PCSource = PCSRC_JUMP;
      end
      S_ADDI_WB: begin
        RegWrite = 1'b1;
      end
      default: ;
    endcase
  end

  assign state_out = state_q;

endmodule

// File: tb/tb_main_control_fsm.sv
module tb_main_control_fsm;
  import mips_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic [2:0] rst_v;
  logic [5:0] opcode;
  logic [18:0] act_v [3];
  int         sel;

  always #5 clk = ~clk;

  // Instance 0: MEM_WAIT=1, instance 1: MEM_WAIT=0, instance 2: MEM_WAIT=3.
  // Only the instance named by sel is out of reset and checked.
  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_dut
      localparam int unsigned W = (gi == 0) ? 1 : (gi == 1) ? 0 : 3;
      logic pcw, pcwc, iord, memw, irw, regdst, m2r, regw, srca;
      logic [1:0] srcb, ula, pcsrc;
      logic [3:0] st;
      main_control_fsm #(.MEM_WAIT(W)) u_dut (
        .clk(clk), .reset(rst_v[gi]), .opcode(opcode),
        .PCWrite(pcw), .PCWriteCond(pcwc), .IorD(iord), .MemWrite(memw),
        .IRWrite(irw), .RegDst(regdst), .MemtoReg(m2r), .RegWrite(regw),
        .ALUSrcA(srca), .ALUSrcB(srcb), .ULAOp(ula), .PCSource(pcsrc),
        .state_out(st)
      );
      assign act_v[gi] = {st, pcw, pcwc, iord, memw, irw, regdst, m2r, regw,
                          srca, srcb, ula, pcsrc};
    end
  endgenerate

  typedef struct {
    state_t      s;
    logic [18:0] v;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc   = 0;

  // Expected outputs per state, straight from the state/output table.
  // Vector: {state, PCWrite, PCWriteCond, IorD, MemWrite, IRWrite, RegDst,
  //          MemtoReg, RegWrite, ALUSrcA, ALUSrcB, ULAOp, PCSource}
  function automatic logic [18:0] exp_vec(input state_t s, input bit fin);
    logic pcw = 0, pcwc = 0, iord = 0, memw = 0, irw = 0, regdst = 0;
    logic m2r = 0, regw = 0, srca = 0;
    logic [1:0] srcb = 2'b00, ula = 2'b00, pcsrc = 2'b00;
    case (s)
      S_FETCH:     begin srcb = 2'b01; irw = fin; pcw = fin; end
      S_DECODE:    begin srcb = 2'b11; end
      S_MEM_ADDR:  begin srca = 1; srcb = 2'b10; end
      S_MEM_READ:  begin iord = 1; end
      S_LOAD_WB:   begin m2r = 1; regw = 1; end
      S_MEM_WRITE: begin iord = 1; memw = fin; end
      S_R_EXEC:    begin srca = 1; ula = 2'b10; end
      S_R_WB:      begin regdst = 1; regw = 1; end
      S_BRANCH:    begin srca = 1; ula = 2'b01; pcwc = 1; pcsrc = 2'b01; end
      S_JUMP:      begin pcw = 1; pcsrc = 2'b10; end
      S_ADDI_EXEC: begin srca = 1; srcb = 2'b10; end
      S_ADDI_WB:   begin regw = 1; end
      default: ;
    endcase
    return {s, pcw, pcwc, iord, memw, irw, regdst, m2r, regw, srca, srcb, ula, pcsrc};
  endfunction

  task automatic push(input state_t s, input bit fin);
    exp_t e;
    e.s = s;
    e.v = exp_vec(s, fin);
    exp_q.push_back(e);
  endtask

  // Monitor: every falling edge, one expected cycle is compared.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      n_cmp++;
      if (act_v[sel] !== e.v) begin
        n_err++;
        $display("FAIL cyc%0d inst%0d state_%s: actual=%05h required=%05h",
                 cyc, sel, e.s.name(), act_v[sel], e.v);
      end else begin
        $display("ok   cyc%0d inst%0d %s vec=%05h", cyc, sel, e.s.name(), e.v);
      end
    end
    cyc++;
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Called 2ns into the first FETCH cycle. opcode carries junk except in DECODE.
  task automatic run_instr(input logic [5:0] op, input int w);
    int n = 0;
    for (int i = 0; i <= w; i++) begin push(S_FETCH, i == w); n++; end
    push(S_DECODE, 0); n++;
    case (op)
      6'h23: begin
        push(S_MEM_ADDR, 0); n++;
        for (int i = 0; i <= w; i++) begin push(S_MEM_READ, i == w); n++; end
        push(S_LOAD_WB, 0); n++;
      end
      6'h2B: begin
        push(S_MEM_ADDR, 0); n++;
        for (int i = 0; i <= w; i++) begin push(S_MEM_WRITE, i == w); n++; end
      end
      6'h00: begin push(S_R_EXEC, 0); push(S_R_WB, 0); n += 2; end
      6'h08: begin push(S_ADDI_EXEC, 0); push(S_ADDI_WB, 0); n += 2; end
      6'h04: begin push(S_BRANCH, 0); n++; end
      6'h02: begin push(S_JUMP, 0); n++; end
      default: ;
    endcase
    opcode = 6'($urandom);
    repeat (w + 1) tick();
    opcode = op;
    tick();
    opcode = (op == 6'h23) ? 6'h2B : 6'($urandom);  // lw must not follow live IR
    repeat (n - w - 2) tick();
  endtask

  // lw aborted by reset in the second MEM_READ cycle (needs w >= 1).
  task automatic abort_lw(input int w);
    for (int i = 0; i <= w; i++) push(S_FETCH, i == w);
    push(S_DECODE, 0);
    push(S_MEM_ADDR, 0);
    push(S_MEM_READ, 0);
    repeat (w + 1) tick();
    opcode = 6'h23;
    tick();
    opcode = 6'h00;
    repeat (2) tick();
    rst_v[sel] = 1'b1;  // outputs must drop within this same cycle
    push(S_RESET, 0);
    tick();
    push(S_RESET, 0);
    rst_v[sel] = 1'b0;
    tick();
  endtask

  task automatic switch_to(input int k);
    rst_v[sel] = 1'b1;
    sel = k;
    rst_v[k] = 1'b0;
    push(S_RESET, 0);
    tick();
  endtask

  initial begin
    rst_v  = 3'b111;
    opcode = 6'h00;
    sel    = 0;
    repeat (3) push(S_RESET, 0);
    repeat (3) @(posedge clk);
    #2;
    rst_v[0] = 1'b0;
    tick();
    run_instr(6'h00, 1);
    run_instr(6'h23, 1);
    run_instr(6'h2B, 1);
    run_instr(6'h04, 1);
    run_instr(6'h02, 1);
    run_instr(6'h08, 1);
    run_instr(6'h3F, 1);
    abort_lw(1);
    run_instr(6'h00, 1);
    switch_to(1);
    run_instr(6'h23, 0);
    run_instr(6'h2B, 0);
    switch_to(2);
    run_instr(6'h23, 3);
    run_instr(6'h04, 3);
    @(negedge clk);
    #1;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: actual=%0d pending required=0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/main_control_fsm.md
# main_control_fsm

Multicycle MIPS main control unit: a Moore state machine that sequences fetch, decode, execute, memory and write-back for each instruction. It drives every datapath enable and mux select, and issues the 2-bit ULAOp consumed by the ALU control decoder (00 = add, 01 = subtract, 10 = decode funct). It sits between the instruction register's opcode field and the datapath. Memory accesses are stretched by a fixed wait count.

## Interface
Parameters:
- MEM_WAIT, default 1: extra cycles per memory access (0–15); each memory state lasts MEM_WAIT+1 cycles.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high
- opcode  in  6  IR[31:26]; sampled only in DECODE
- PCWrite  out  1  unconditional PC load
- PCWriteCond  out  1  PC load if ALU zero (the datapath does the AND)
- IorD  out  1  memory address: 0 = PC, 1 = ALUOut
- MemWrite  out  1  memory write strobe
- IRWrite  out  1  IR load
- RegDst  out  1  0 = rt, 1 = rd
- MemtoReg  out  1  0 = ALUOut, 1 = MDR
- RegWrite  out  1  register file write
- ALUSrcA  out  1  0 = PC, 1 = A
- ALUSrcB  out  2  00 = B, 01 = 4, 10 = signext imm, 11 = signext imm<<2
- ULAOp  out  2  00 add, 01 sub, 10 R-type
- PCSource  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target
- state_out  out  4  current state encoding, for debug

## Operation
- Outputs are a pure function of the state register and the wait counter. No combinational path runs from opcode to any output.
- Every output not listed for a state is 0.
- Opcodes: R = 0x00, lw = 0x23, sw = 0x2B, beq = 0x04, j = 0x02, addi = 0x08.

States and outputs:
- RESET: all outputs 0. Next state is FETCH.
- FETCH: IorD=0, ALUSrcA=0, ALUSrcB=01, ULAOp=00, PCSource=00. IRWrite=1 and PCWrite=1 only in the final wait cycle. Next state is DECODE.
- DECODE: ALUSrcA=0, ALUSrcB=11, ULAOp=00. Branches on opcode to MEM_ADDR (lw/sw), R_EXEC, BRANCH, JUMP, or ADDI_EXEC. Any other opcode goes to FETCH, so the instruction acts as a NOP.
- MEM_ADDR: ALUSrcA=1, ALUSrcB=10, ULAOp=00. Next state is MEM_READ for lw, MEM_WRITE for sw. The opcode is latched in DECODE into an internal register so this branch does not depend on live IR.
- MEM_READ: IorD=1 for MEM_WAIT+1 cycles. Next state is LOAD_WB.
- LOAD_WB: RegDst=0, MemtoReg=1, RegWrite=1. Next state is FETCH.
- MEM_WRITE: IorD=1. MemWrite=1 only in the final wait cycle. Next state is FETCH.
- R_EXEC: ALUSrcA=1, ALUSrcB=00, ULAOp=10. Next state is R_WB.
- R_WB: RegDst=1, MemtoReg=0, RegWrite=1. Next state is FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ULAOp=01, PCWriteCond=1, PCSource=01. Next state is FETCH.
- JUMP: PCWrite=1, PCSource=10. Next state is FETCH.
- ADDI_EXEC: ALUSrcA=1, ALUSrcB=10, ULAOp=00. Next state is ADDI_WB.
- ADDI_WB: RegDst=0, MemtoReg=0, RegWrite=1. Next state is FETCH.

Wait counter:
- Clears on entry to FETCH, MEM_READ and MEM_WRITE.
- Increments each cycle while in those states.
- The state exits when the counter equals MEM_WAIT.
- With MEM_WAIT=0 each memory state lasts exactly one cycle, and its strobe is asserted in that cycle.

## Timing
- Reset asserted (any cycle, including mid-instruction or mid-wait): state goes to RESET, counter and latched opcode go to 0, all outputs go to 0 immediately (asynchronously).
- First FETCH cycle: the first rising edge after reset deasserts.
- Cycles per instruction with W = MEM_WAIT:
  - lw = 2W+5
  - sw = 2W+4
  - R-type and addi = W+4
  - beq and j = W+3
  - illegal opcode = W+2
- IRWrite and PCWrite in FETCH are asserted for exactly one cycle per instruction.
- RegWrite and MemWrite are each asserted for at most one cycle per instruction.
- opcode need only be valid in the DECODE cycle.

## Structure
- Package mips_ctrl_pkg holds:
  - state_t enum (4-bit)
  - opcode constants
  - ULAOp constants (ULA_ADD = 00, ULA_SUB = 01, ULA_RTYPE = 10), shared with the ALU control decoder
  - ALUSrcB and PCSource encodings
- Sub-module mem_wait_counter: 4-bit counter with clear and increment inputs and a done flag (count == MEM_WAIT), instantiated once.

## Test plan
- Reset held for 3 cycles, then released with MEM_WAIT=1 → all outputs 0 during reset; FETCH on the first edge after release; IRWrite=PCWrite=1 on the 2nd FETCH cycle only.
- opcode=0x00 → states FETCH, FETCH, DECODE, R_EXEC (ULAOp=10), R_WB (RegWrite=1, RegDst=1), then FETCH: 5 cycles.
- opcode=0x23 → MEM_READ holds IorD=1 for 2 cycles; LOAD_WB has MemtoReg=1, RegWrite=1: 7 cycles total. opcode=0x2B → MemWrite pulses for exactly 1 cycle: 6 cycles total.
- opcode=0x04 → BRANCH with ULAOp=01, PCWriteCond=1, PCSource=01. opcode=0x02 → JUMP with PCWrite=1, PCSource=10. Each takes 4 cycles.
- opcode=0x3F → DECODE goes to FETCH; no RegWrite, MemWrite or extra PCWrite. Changing opcode after DECODE during an lw still yields LOAD_WB.
- Reset asserted in the second MEM_READ cycle → outputs 0 in the same cycle; after release, restart at FETCH with the counter cleared. Repeat the lw timing with MEM_WAIT=0 (expect 5 cycles) and MEM_WAIT=3 (expect 11 cycles).
